// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch stage with ITLB lookup, one outstanding imem request and a stall buffer
module cpu_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_1000,
    parameter logic [31:0] EXCEPTION_PC = 32'h0000_2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    input  logic        rm4,
    output logic [31:0] itlb_vaddr,
    input  logic        itlb_hit,
    input  logic [31:0] itlb_paddr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic [31:0] next_PC,
    output logic        nop,
    output logic        tlb_exc_raise,
    output logic [31:0] tlb_exc_pc,
    output logic [31:0] tlb_exc_vaddr
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, pc_plus4;
    logic        buf_valid, buf_valid_next;
    logic [31:0] buf_instr, buf_instr_next;
    logic [31:0] buf_npc, buf_npc_next;
    logic [31:0] instr_next, next_pc_next, exc_pc_next, exc_vaddr_next;
    logic        nop_next, exc_raise_next, itlb_miss;

    assign itlb_vaddr = pc;
    assign pc_plus4   = pc + 32'd4;
    assign itlb_miss  = (state == S_FETCH) && !buf_valid && !rm4 && !itlb_hit;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        buf_valid_next = buf_valid;
        buf_instr_next = buf_instr;
        buf_npc_next   = buf_npc;
        instr_next     = instr;
        next_pc_next   = next_PC;
        nop_next       = nop;
        exc_raise_next = tlb_exc_raise;
        exc_pc_next    = tlb_exc_pc;
        exc_vaddr_next = tlb_exc_vaddr;
        imem_req_valid = 1'b0;
        imem_req_addr  = rm4 ? pc : itlb_paddr;

        if (reset) begin
            // A response still owed by memory must be swallowed after reset.
            state_next     = (state != S_FETCH && !imem_rsp_valid) ? S_DRAIN : S_FETCH;
            pc_next        = RESET_PC;
            buf_valid_next = 1'b0;
            instr_next     = 32'd0;
            next_pc_next   = 32'd0;
            nop_next       = 1'b1;
            exc_raise_next = 1'b0;
            exc_pc_next    = 32'd0;
            exc_vaddr_next = 32'd0;
        end else if (jump) begin
            pc_next        = jump_pc;
            buf_valid_next = 1'b0;
            instr_next     = 32'd0;
            nop_next       = 1'b1;
            exc_raise_next = 1'b0;
            if (state != S_FETCH) begin
                state_next = imem_rsp_valid ? S_FETCH : S_DRAIN;
            end
        end else if (state == S_DRAIN) begin
            if (imem_rsp_valid) begin
                state_next = S_FETCH;
            end
        end else if (itlb_miss && !stall) begin
            exc_raise_next = 1'b1;
            exc_pc_next    = pc;
            exc_vaddr_next = pc;
            instr_next     = 32'd0;
            nop_next       = 1'b1;
            pc_next        = EXCEPTION_PC;
        end else if (stall) begin
            if (state == S_WAIT && imem_rsp_valid) begin
                buf_valid_next = 1'b1;
                buf_instr_next = imem_rsp_data;
                buf_npc_next   = pc_plus4;
                pc_next        = pc_plus4;
                state_next     = S_FETCH;
            end
        end else begin
            exc_raise_next = 1'b0;
            instr_next     = 32'd0;
            nop_next       = 1'b1;
            case (state)
                S_FETCH: begin
                    if (buf_valid) begin
                        instr_next     = buf_instr;
                        next_pc_next   = buf_npc;
                        nop_next       = 1'b0;
                        buf_valid_next = 1'b0;
                    end else begin
                        imem_req_valid = 1'b1;
                        if (imem_req_ready) begin
                            state_next = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_next   = imem_rsp_data;
                        next_pc_next = pc_plus4;
                        nop_next     = 1'b0;
                        pc_next      = pc_plus4;
                        state_next   = S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        state         <= state_next;
        pc            <= pc_next;
        buf_valid     <= buf_valid_next;
        buf_instr     <= buf_instr_next;
        buf_npc       <= buf_npc_next;
        instr         <= instr_next;
        next_PC       <= next_pc_next;
        nop           <= nop_next;
        tlb_exc_raise <= exc_raise_next;
        tlb_exc_pc    <= exc_pc_next;
        tlb_exc_vaddr <= exc_vaddr_next;
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - directed and randomized self-checking bench for cpu_fetch
module tb_cpu_fetch;

    logic        clock = 1'b0;
    logic        reset, stall, jump, rm4, itlb_hit, imem_req_ready, imem_rsp_valid;
    logic [31:0] jump_pc, itlb_paddr, imem_rsp_data;
    logic [31:0] itlb_vaddr, imem_req_addr, instr, next_PC, tlb_exc_pc, tlb_exc_vaddr;
    logic        imem_req_valid, nop, tlb_exc_raise;

    int checks = 0;
    int errors = 0;

    cpu_fetch dut (
        .clock(clock), .reset(reset), .stall(stall), .jump(jump), .jump_pc(jump_pc),
        .rm4(rm4), .itlb_vaddr(itlb_vaddr), .itlb_hit(itlb_hit), .itlb_paddr(itlb_paddr),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr(instr), .next_PC(next_PC), .nop(nop),
        .tlb_exc_raise(tlb_exc_raise), .tlb_exc_pc(tlb_exc_pc), .tlb_exc_vaddr(tlb_exc_vaddr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: outstanding request tracked as none/live/stale, stall buffer as a queue.
    typedef struct {
        logic [31:0] i;
        logic [31:0] n;
    } ent_t;
    localparam int P_NONE = 0, P_LIVE = 1, P_STALE = 2;
    ent_t        m_buf[$];
    int          m_pend;
    logic [31:0] m_pc, e_instr, e_npc, e_epc, e_eva;
    logic        e_nop, e_raise, e_v;
    bit          r_out;
    int          r_cnt;

    task automatic model_update();
        bit live;
        ent_t e;
        live = imem_rsp_valid && (m_pend == P_LIVE);
        if (reset) begin
            m_pend = (m_pend != P_NONE && !imem_rsp_valid) ? P_STALE : P_NONE;
            m_pc = 32'h0000_1000;
            m_buf.delete();
            e_instr = 0; e_npc = 0; e_nop = 1; e_raise = 0; e_epc = 0; e_eva = 0;
        end else if (jump) begin
            m_pc = jump_pc;
            m_buf.delete();
            e_instr = 0; e_nop = 1; e_raise = 0;
            if (m_pend != P_NONE) m_pend = imem_rsp_valid ? P_NONE : P_STALE;
        end else if (m_pend == P_STALE) begin
            if (imem_rsp_valid) m_pend = P_NONE;
        end else if (m_pend == P_NONE && m_buf.size() == 0 && !rm4 && !itlb_hit && !stall) begin
            e_raise = 1; e_epc = m_pc; e_eva = m_pc; e_nop = 1; e_instr = 0;
            m_pc = 32'h0000_2000;
        end else if (stall) begin
            if (live) begin
                e.i = imem_rsp_data;
                e.n = m_pc + 32'd4;
                m_buf.push_back(e);
                m_pc = m_pc + 32'd4;
                m_pend = P_NONE;
            end
        end else begin
            e_raise = 0;
            if (m_buf.size() != 0) begin
                e = m_buf.pop_front();
                e_instr = e.i; e_npc = e.n; e_nop = 0;
            end else if (live) begin
                e_instr = imem_rsp_data; e_npc = m_pc + 32'd4; e_nop = 0;
                m_pc = m_pc + 32'd4;
                m_pend = P_NONE;
            end else begin
                e_instr = 0; e_nop = 1;
                if (e_v && imem_req_ready) m_pend = P_LIVE;
            end
        end
    endtask

    task automatic chk_held(input string tag);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_nop"}, {31'd0, nop}, 32'd1);
        chk({tag, "_npc"}, next_PC, 32'h0000_1004);
    endtask

    initial begin
        bit acc;
        reset = 1; stall = 0; jump = 0; jump_pc = 0; rm4 = 0; itlb_hit = 0;
        itlb_paddr = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        tick(); tick();
        chk("rst_instr", instr, 0);
        chk("rst_npc", next_PC, 0);
        chk("rst_nop", {31'd0, nop}, 1);
        chk("rst_raise", {31'd0, tlb_exc_raise}, 0);
        chk("rst_epc", tlb_exc_pc, 0);
        chk("rst_evaddr", tlb_exc_vaddr, 0);
        chk("rst_reqv", {31'd0, imem_req_valid}, 0);
        chk("rst_vaddr", itlb_vaddr, 32'h1000);

        // Basic fetch in supervisor mode
        reset = 0; rm4 = 1; imem_req_ready = 1; #1;
        chk("f_reqv", {31'd0, imem_req_valid}, 1);
        chk("f_addr", imem_req_addr, 32'h1000);
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; #1;
        chk("f_wait_reqv", {31'd0, imem_req_valid}, 0);
        tick();
        imem_rsp_valid = 0;
        chk("f_instr", instr, 32'hDEAD_BEEF);
        chk("f_npc", next_PC, 32'h1004);
        chk("f_nop", {31'd0, nop}, 0);
        tick();
        chk("f_bubble_nop", {31'd0, nop}, 1);
        chk("f_bubble_instr", instr, 0);

        // Jump while waiting: response dropped
        imem_req_ready = 1; #1;
        chk("j_addr", imem_req_addr, 32'h1004);
        tick();
        imem_req_ready = 0; jump = 1; jump_pc = 32'h3000;
        tick();
        jump = 0; #1;
        chk("j_nop", {31'd0, nop}, 1);
        chk("j_vaddr", itlb_vaddr, 32'h3000);
        chk("j_drain_reqv", {31'd0, imem_req_valid}, 0);
        tick();
        imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111;
        tick();
        imem_rsp_valid = 0; #1;
        chk("j_drop_instr", instr, 0);
        chk("j_drop_nop", {31'd0, nop}, 1);
        chk("j_next_reqv", {31'd0, imem_req_valid}, 1);
        chk("j_next_addr", imem_req_addr, 32'h3000);
        imem_req_ready = 1;
        tick();

        // Stall with response arriving during stall
        imem_req_ready = 0; stall = 1;
        tick();
        chk_held("s1");
        chk("s1_reqv", {31'd0, imem_req_valid}, 0);
        imem_rsp_valid = 1; imem_rsp_data = 32'h2222_2222;
        tick();
        imem_rsp_valid = 0; #1;
        chk_held("s2");
        chk("s2_reqv", {31'd0, imem_req_valid}, 0);
        tick();
        chk_held("s3");
        stall = 0; #1;
        chk("s_buf_reqv", {31'd0, imem_req_valid}, 0);
        tick();
        chk("s_instr", instr, 32'h2222_2222);
        chk("s_npc", next_PC, 32'h3004);
        chk("s_nop", {31'd0, nop}, 0);
        tick();
        chk("s_once_instr", instr, 0);
        chk("s_once_nop", {31'd0, nop}, 1);

        // ITLB miss
        jump = 1; jump_pc = 32'h1008;
        tick();
        jump = 0; rm4 = 0; itlb_hit = 0; #1;
        chk("m_reqv", {31'd0, imem_req_valid}, 0);
        tick();
        chk("m_raise", {31'd0, tlb_exc_raise}, 1);
        chk("m_epc", tlb_exc_pc, 32'h1008);
        chk("m_evaddr", tlb_exc_vaddr, 32'h1008);
        chk("m_nop", {31'd0, nop}, 1);
        rm4 = 1; #1;
        chk("m_next_reqv", {31'd0, imem_req_valid}, 1);
        chk("m_next_addr", imem_req_addr, 32'h2000);
        tick();
        chk("m_raise_once", {31'd0, tlb_exc_raise}, 0);

        // Translated address held while ready is low
        rm4 = 0; itlb_hit = 1; itlb_paddr = 32'h8000; imem_req_ready = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t_hold_reqv", {31'd0, imem_req_valid}, 1);
            chk("t_hold_addr", imem_req_addr, 32'h8000);
            tick();
        end
        imem_req_ready = 1; #1;
        chk("t_acc_reqv", {31'd0, imem_req_valid}, 1);
        chk("t_acc_addr", imem_req_addr, 32'h8000);
        tick();
        imem_req_ready = 0; #1;
        chk("t_wait_reqv", {31'd0, imem_req_valid}, 0);
        imem_rsp_valid = 1; imem_rsp_data = 32'h4444_4444;
        tick();
        imem_rsp_valid = 0;
        chk("t_instr", instr, 32'h4444_4444);
        chk("t_npc", next_PC, 32'h2004);

        // PC wrap
        rm4 = 1; jump = 1; jump_pc = 32'hFFFF_FFFC;
        tick();
        jump = 0; imem_req_ready = 1; #1;
        chk("w_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h5555_5555;
        tick();
        imem_rsp_valid = 0;
        chk("w_instr", instr, 32'h5555_5555);
        chk("w_npc", next_PC, 32'h0000_0000);
        chk("w_vaddr", itlb_vaddr, 32'h0000_0000);

        // Reset while a request is outstanding
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0; reset = 1;
        tick();
        reset = 0; imem_req_ready = 1; #1;
        chk("r_drain_reqv", {31'd0, imem_req_valid}, 0);
        chk("r_nop", {31'd0, nop}, 1);
        tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h6666_6666;
        tick();
        imem_rsp_valid = 0; #1;
        chk("r_drop_instr", instr, 0);
        chk("r_drop_nop", {31'd0, nop}, 1);
        chk("r_next_reqv", {31'd0, imem_req_valid}, 1);
        chk("r_next_addr", imem_req_addr, 32'h1000);

        // Randomized run against the reference model
        reset = 1;
        tick();
        m_pc = 32'h1000; m_pend = P_NONE; m_buf.delete();
        e_instr = 0; e_npc = 0; e_nop = 1; e_raise = 0; e_epc = 0; e_eva = 0;
        r_out = 0; r_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom % 100) == 0;
            stall          = ($urandom % 5) == 0;
            jump           = ($urandom % 20) == 0;
            jump_pc        = $urandom & 32'hFFFF_FFFC;
            rm4            = ($urandom % 10) < 7;
            itlb_hit       = ($urandom % 10) < 8;
            itlb_paddr     = $urandom & 32'hFFFF_FFFC;
            imem_req_ready = ($urandom % 10) < 6;
            imem_rsp_valid = r_out && (r_cnt == 0);
            imem_rsp_data  = $urandom;
            #1;
            e_v = !reset && !jump && !stall && m_pend == P_NONE && m_buf.size() == 0
                  && (rm4 || itlb_hit);
            chk("rnd_vaddr", itlb_vaddr, m_pc);
            chk("rnd_reqv", {31'd0, imem_req_valid}, {31'd0, e_v});
            if (e_v) chk("rnd_addr", imem_req_addr, rm4 ? m_pc : itlb_paddr);
            acc = imem_req_valid && imem_req_ready;
            model_update();
            tick();
            chk("rnd_instr", instr, e_instr);
            chk("rnd_npc", next_PC, e_npc);
            chk("rnd_nop", {31'd0, nop}, {31'd0, e_nop});
            chk("rnd_raise", {31'd0, tlb_exc_raise}, {31'd0, e_raise});
            chk("rnd_epc", tlb_exc_pc, e_epc);
            chk("rnd_evaddr", tlb_exc_vaddr, e_eva);
            if (imem_rsp_valid) r_out = 0;
            else if (r_out) r_cnt--;
            if (acc) begin
                r_out = 1;
                r_cnt = $urandom_range(0, 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_1000, PC loaded on reset.
REQ-002 SHALL have parameter EXCEPTION_PC, 32'h0000_2000, redirect target on ITLB miss.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  hazard-unit stall; hold the decode outputs.
REQ-006 SHALL have port jump  input  1  redirect request from decode.
REQ-007 SHALL have port jump_pc  input  32  redirect target.
REQ-008 SHALL have port rm4  input  1  supervisor mode; 1 = no translation.
REQ-009 SHALL have port itlb_vaddr  output  32  current PC, driven to the ITLB.
REQ-010 SHALL have ports itlb_hit (input, 1) and itlb_paddr (input, 32), combinational ITLB result.
REQ-011 SHALL have ports imem_req_valid (output, 1), imem_req_addr (output, 32) and imem_req_ready (input, 1), the request channel.
REQ-012 SHALL have ports imem_rsp_valid (input, 1) and imem_rsp_data (input, 32), the response channel.
REQ-013 SHALL have decode outputs: instr 32, next_PC 32, nop 1, tlb_exc_raise 1, tlb_exc_pc 32, tlb_exc_vaddr 32.

Function
REQ-014 SHALL hold at most one imem request outstanding at any time.
REQ-015 SHALL implement three states: FETCH (may issue), WAIT (request accepted, response awaited), DRAIN (response awaited and to be discarded).
REQ-016 SHALL, in FETCH with stall=0, buffer empty and no jump, assert imem_req_valid with imem_req_addr = (rm4 ? PC : itlb_paddr).
REQ-017 SHALL treat a request as accepted when imem_req_valid=1 and imem_req_ready=1 in the same cycle, then go to WAIT.
REQ-018 SHALL keep the same address while waiting for ready.
REQ-019 SHALL, in WAIT on imem_rsp_valid=1, register the instruction and return to FETCH.
REQ-020 SHALL, for a registered instruction, present instr=imem_rsp_data, next_PC=PC+4 (modulo 2^32) and nop=0 on the next cycle.
REQ-021 SHALL advance PC by 4 on that capture.
REQ-022 SHALL set nop=1 and instr=0 in every cycle without a new valid instruction and stall=0.
REQ-023 SHALL, when stall=1, hold instr/next_PC/nop/tlb_exc_* unchanged and issue no new request.
REQ-024 SHALL, on a response during stall, capture it into a one-entry buffer.
REQ-025 SHALL present a buffered entry in the first cycle after stall falls, then clear the buffer.
REQ-026 SHALL, on jump=1 (stall ignored), set PC=jump_pc, set nop=1 next cycle and clear the buffer.
REQ-027 SHALL, on jump=1 in WAIT, move to DRAIN.
REQ-028 SHALL, on jump=1 with an unaccepted request, withdraw the request and stay in FETCH.
REQ-029 SHALL, in DRAIN, discard the response and return to FETCH with no output change.
REQ-030 SHALL, on a new jump in DRAIN, update PC and remain in DRAIN.
REQ-031 SHALL, in FETCH with rm4=0, itlb_hit=0, stall=0 and no jump, issue no request.
REQ-032 SHALL, in that miss case, set tlb_exc_raise=1, tlb_exc_pc=PC, tlb_exc_vaddr=PC and nop=1 for one cycle.
REQ-033 SHALL, on an ITLB miss, set PC=EXCEPTION_PC.
REQ-034 SHALL apply priority reset > jump > ITLB miss > stall > normal.
REQ-035 SHALL drive itlb_vaddr=PC combinationally in all states.

Reset
REQ-036 SHALL, with reset=1 at a clock edge, set PC=RESET_PC, state=FETCH and buffer empty.
REQ-037 SHALL, on reset, set instr=0, next_PC=0, nop=1, tlb_exc_raise=0, tlb_exc_pc=0 and tlb_exc_vaddr=0.
REQ-038 SHALL keep imem_req_valid=0 during reset.
REQ-039 SHALL, on reset mid-WAIT, enter DRAIN instead of FETCH so the stale response is discarded.

Verification
REQ-040 SHALL check: reset then rm4=1, ready=1, rsp one cycle later with 32'hDEAD_BEEF -> req addr 0x1000, then instr=0xDEADBEEF, next_PC=0x1004, nop=0.
REQ-041 SHALL check: jump=1, jump_pc=0x3000 while in WAIT; rsp 0x11111111 two cycles later -> response dropped, nop=1, next req addr 0x3000.
REQ-042 SHALL check: stall=1 for 3 cycles and rsp 0x22222222 during stall -> outputs held, no req; after stall falls instr=0x22222222 once.
REQ-043 SHALL check: rm4=0, itlb_hit=0, PC=0x1008 -> tlb_exc_raise=1 and tlb_exc_pc=tlb_exc_vaddr=0x1008 for one cycle; next req addr 0x2000 with rm4=1.
REQ-044 SHALL check: rm4=0, itlb_hit=1, itlb_paddr=0x8000, ready=0 for 4 cycles -> addr 0x8000 held valid throughout; accepted on the 5th cycle.
REQ-045 SHALL check: PC=0xFFFF_FFFC fetched -> next_PC=0x0000_0000.
